// File: rtl/pipelined_adder_pkg.sv
// Shared types, defaults and helpers for the pipelined adder/subtractor.
// Imported by the interface and the top level.
package pipelined_adder_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // The pipeline may move whenever the output register is empty or being drained.
    function automatic logic hs_advance(input logic out_valid, input logic out_ready);
        return !out_valid || out_ready;
    endfunction

    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result valid-ready bundle for the pipelined adder.
// The slave modport is the adder's view; master is the source/consumer view.
interface pipelined_adder_if
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );

endinterface

// File: rtl/pipelined_adder_add_slice.sv
// Combinational SLICE-bit ripple adder built from a chain of full-adder cells.
// Also exposes the carry into the slice MSB so the last stage can derive overflow.
module add_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [SLICE:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout     = c[SLICE];
    assign c_msb_in = c[SLICE-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: one SLICE-bit slice resolves per stage,
// with the carry and the not-yet-used operand bits registered between stages.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input logic              clk,
    input logic              rst_n,
    pipelined_adder_if.slave bus
);

    localparam int SLICE = WIDTH / STAGES;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("pipelined_adder: WIDTH=%0d must be a multiple of STAGES=%0d", WIDTH, STAGES);
    end

    logic                adv;

    logic [WIDTH-1:0]    a_src [STAGES];
    logic [WIDTH-1:0]    b_src [STAGES];
    logic [STAGES-1:0]   c_src;
    logic [STAGES-1:0]   v_src;

    logic [SLICE-1:0]    s_w [STAGES];
    logic [STAGES-1:0]   cout_w;
    logic [STAGES-1:0]   cmsb_w;

    // a_q words hold finished sum slices below the current stage and raw A above it.
    logic [WIDTH-1:0]    a_q [STAGES];
    logic [WIDTH-1:0]    a_d [STAGES];
    logic [WIDTH-1:0]    b_q [STAGES];
    logic [WIDTH-1:0]    b_d [STAGES];
    logic [STAGES-1:0]   carry_q, carry_d;
    logic [STAGES-1:0]   valid_q, valid_d;
    logic                ovf_q, ovf_d;

    logic                unused_ok;

    assign adv          = hs_advance(valid_q[STAGES-1], bus.out_ready);
    assign bus.in_ready = adv;

    always_comb begin
        a_src[0] = bus.in_a;
        b_src[0] = (op_e'(bus.in_sub) == OP_SUB) ? ~bus.in_b : bus.in_b;
        c_src    = '0;
        v_src    = '0;
        c_src[0] = (op_e'(bus.in_sub) == OP_SUB) ? 1'b1 : bus.in_cin;
        v_src[0] = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            c_src[k] = carry_q[k-1];
            v_src[k] = valid_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        add_slice #(
            .SLICE (SLICE)
        ) u_slice (
            .a        (a_src[k][k*SLICE +: SLICE]),
            .b        (b_src[k][k*SLICE +: SLICE]),
            .cin      (c_src[k]),
            .s        (s_w[k]),
            .cout     (cout_w[k]),
            .c_msb_in (cmsb_w[k])
        );
    end

    // Every stage shifts together, valid or not, so bubbles never block later beats.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_d[k]                  = a_src[k];
                a_d[k][k*SLICE +: SLICE] = s_w[k];
                b_d[k]                  = b_src[k];
                carry_d[k]              = cout_w[k];
                valid_d[k]              = v_src[k];
            end
            ovf_d = cout_w[STAGES-1] ^ cmsb_w[STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '{default: '0};
            b_q     <= '{default: '0};
            carry_q <= '0;
            valid_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.out_sum   = a_q[STAGES-1];
    assign bus.out_cout  = carry_q[STAGES-1];
    assign bus.out_ovf   = ovf_q;

    // Operand B is fully consumed by the last stage; MSB carries matter only there.
    assign unused_ok = ^{b_q[STAGES-1], cmsb_w};

endmodule
